// File: rtl/monitor_temperatura_multicanal_pkg.sv
// Shared encodings for the multichannel temperature monitor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package monitor_temp_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t NORMAL   = 2'd0;
    localparam estado_t SUSPEITO = 2'd1;
    localparam estado_t ALARME   = 2'd2;
    localparam estado_t RETORNO  = 2'd3;

    localparam int CNT_W  = 4;
    localparam int FO_W   = 4;
    localparam int MAX_CH = 16;

    // Lowest set bit wins, so simultaneous risers report the smallest channel.
    function automatic logic [FO_W-1:0] primeiro_idx(input logic [MAX_CH-1:0] v);
        primeiro_idx = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (v[i]) primeiro_idx = FO_W'(i);
        end
    endfunction

endpackage

// File: rtl/monitor_temperatura_multicanal_if.sv
// Sensor bus, thresholds, operator ack and panel alarm outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the sensor bus is sampled whenever amostra_valida is high.
interface monitor_temperatura_multicanal_if #(
    parameter int N_CH = 7,
    parameter int W    = 9
);
    import monitor_temp_pkg::*;

    logic                amostra_valida;
    logic [N_CH*W-1:0]   sens_temp;
    logic [N_CH*W-1:0]   limiar;
    logic                ack;
    logic [N_CH-1:0]     alarme_canal;
    logic [N_CH-1:0]     alarme_memorizado;
    logic                alarme_sonoro_temperatura;
    logic [FO_W-1:0]     primeiro_canal;
    logic                primeiro_valido;

    modport master (
        output amostra_valida, sens_temp, limiar, ack,
        input  alarme_canal, alarme_memorizado, alarme_sonoro_temperatura,
               primeiro_canal, primeiro_valido
    );

    modport slave (
        input  amostra_valida, sens_temp, limiar, ack,
        output alarme_canal, alarme_memorizado, alarme_sonoro_temperatura,
               primeiro_canal, primeiro_valido
    );

endinterface

// File: rtl/monitor_temperatura_multicanal_canal.sv
// Per-channel debounce/hysteresis FSM for one temperature sensor.
// Latency: alarme rises/falls 1 clk after the DEB-th qualifying sample.
// Backpressure: none; cycles without amostra_valida freeze state and counter.
module canal_debounce_temp
    import monitor_temp_pkg::*;
#(
    parameter int W    = 9,
    parameter int DEB  = 3,
    parameter int HIST = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         amostra_valida,
    input  logic [W-1:0] temp,
    input  logic [W-1:0] limiar,
    output logic         alarme,
    output logic         alarme_nxt
);

    localparam logic [W:0]       HIST_W = (W + 1)'(HIST);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             excede, limpa;

    assign excede  = temp >= limiar;
    // One extra bit keeps temp + HIST from wrapping; limiar <= HIST never clears.
    assign limpa   = ({1'b0, temp} + HIST_W) < {1'b0, limiar};
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (amostra_valida) begin
            case (state_q)
                NORMAL: begin
                    cnt_d = '0;
                    if (excede) begin
                        if (DEB_C == CNT_W'(1)) state_d = ALARME;
                        else begin
                            state_d = SUSPEITO;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                SUSPEITO: begin
                    if (!excede) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_C) begin
                        state_d = ALARME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ALARME: begin
                    cnt_d = '0;
                    if (limpa) begin
                        if (DEB_C == CNT_W'(1)) state_d = NORMAL;
                        else begin
                            state_d = RETORNO;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RETORNO: begin
                    if (!limpa) begin
                        state_d = ALARME;
                        cnt_d   = '0;
                    end else if (cnt_inc == DEB_C) begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign alarme_nxt = (state_d == ALARME) || (state_d == RETORNO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            alarme  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alarme  <= alarme_nxt;
        end
    end

endmodule

// File: rtl/monitor_temperatura_multicanal.sv
// Multichannel temperature monitor: per-channel debounce, latched alarms, ack, first-out.
// Latency: all outputs registered, 1 clk after the deciding sample.
// Backpressure: none; samples are consumed on every amostra_valida cycle.
module monitor_temperatura_multicanal
    import monitor_temp_pkg::*;
#(
    parameter int N_CH = 7,
    parameter int W    = 9,
    parameter int DEB  = 3,
    parameter int HIST = 5
) (
    input  logic clk,
    input  logic rst_n,
    monitor_temperatura_multicanal_if.slave bus
);

    logic [N_CH-1:0] canal_q, canal_d;
    logic [N_CH-1:0] mem_q, mem_d;
    logic            sonoro_q;
    logic [FO_W-1:0] primeiro_q;
    logic            primeiro_vld_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_canal
        canal_debounce_temp #(
            .W    (W),
            .DEB  (DEB),
            .HIST (HIST)
        ) u_canal (
            .clk            (clk),
            .rst_n          (rst_n),
            .amostra_valida (bus.amostra_valida),
            .temp           (bus.sens_temp[k*W +: W]),
            .limiar         (bus.limiar[k*W +: W]),
            .alarme         (canal_q[k]),
            .alarme_nxt     (canal_d[k])
        );
    end

    // A channel going active sets its latch even if ack arrives the same cycle.
    always_comb begin
        mem_d = canal_d | (mem_q & ~({N_CH{bus.ack}} & ~canal_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q          <= '0;
            sonoro_q       <= 1'b0;
            primeiro_q     <= '0;
            primeiro_vld_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            sonoro_q <= |mem_d;
            if (mem_d == '0) begin
                primeiro_q     <= '0;
                primeiro_vld_q <= 1'b0;
            end else if (mem_q == '0) begin
                primeiro_q     <= primeiro_idx(MAX_CH'(mem_d));
                primeiro_vld_q <= 1'b1;
            end
        end
    end

    assign bus.alarme_canal              = canal_q;
    assign bus.alarme_memorizado         = mem_q;
    assign bus.alarme_sonoro_temperatura = sonoro_q;
    assign bus.primeiro_canal            = primeiro_q;
    assign bus.primeiro_valido           = primeiro_vld_q;

endmodule

// File: doc/monitor_temperatura_multicanal.md
Name: monitor_temperatura_multicanal

Overview:
- Parametrised successor to the plant's combinational temperature-alarm logic. Watches N_CH temperature sensors against per-channel runtime thresholds (core, S1–S3, tubes SR/SS, reactor), with debounce, hysteresis, latched alarms and operator acknowledge.
- Drives the audible temperature alarm and a first-out channel indicator for the control panel.

Parameters:
N_CH, 7, number of sensor channels (1..16)
W, 9, sensor and threshold width in bits (unsigned)
DEB, 3, consecutive valid samples required to enter or leave alarm (1..15)
HIST, 5, hysteresis in LSBs; a channel clears only when temp + HIST < threshold

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
amostra_valida  in  1  sensor bus holds a new sample set this cycle
sens_temp  in  N_CH*W  packed temperatures; channel k at [k*W +: W]
limiar  in  N_CH*W  packed thresholds; channel k at [k*W +: W]; static while sampling
ack  in  1  operator acknowledge pulse
alarme_canal  out  N_CH  debounced, non-latched per-channel alarm
alarme_memorizado  out  N_CH  latched per-channel alarm
alarme_sonoro_temperatura  out  1  OR of alarme_memorizado
primeiro_canal  out  4  index of the first-out channel
primeiro_valido  out  1  primeiro_canal is meaningful

Behaviour:
- Reset (async assert, sync release):
  - all channel FSMs go to NORMAL and counters to 0.
  - all outputs are 0; primeiro_canal is 0.
- Exceed condition per channel: sens_temp >= limiar (unsigned, W bits).
- Clear condition per channel: sens_temp + HIST < limiar, evaluated in W+1 bits with no wrap. If limiar <= HIST, the channel can never clear.
- Per-channel FSM, advancing only on cycles with amostra_valida=1. Cycles without amostra_valida hold state and counter.
  - NORMAL: on exceed, cnt=1; go to SUSPEITO, or straight to ALARME if DEB=1.
  - SUSPEITO: on exceed, cnt++; when cnt reaches DEB, go to ALARME. A non-exceeding sample returns to NORMAL with cnt=0.
  - ALARME: on clear, cnt=1; go to RETORNO, or straight to NORMAL if DEB=1.
  - RETORNO: on clear, cnt++; when cnt reaches DEB, go to NORMAL. A non-clear sample returns to ALARME with cnt=0.
  - Samples in the hysteresis band (neither exceed nor clear) count as non-exceed in SUSPEITO and non-clear in RETORNO.
- alarme_canal[k] = registered (state ∈ {ALARME, RETORNO}).
  - It rises 1 clk after the cycle carrying the DEB-th consecutive exceeding sample.
- alarme_memorizado[k]:
  - Set in the same cycle alarme_canal[k] is set.
  - Cleared on ack only if alarme_canal[k] is 0 at the ack cycle (the FSM will be NORMAL next).
  - ack while a channel is still active leaves that bit set.
  - Set and ack on the same channel in the same cycle: set wins.
- alarme_sonoro_temperatura: registered OR of the next-state alarme_memorizado, so it has the same timing as alarme_memorizado.
- First-out:
  - Captured when alarme_memorizado goes from all-zero to non-zero.
  - primeiro_canal = lowest index among the bits rising that cycle; primeiro_valido=1.
  - Later alarms do not overwrite it.
  - primeiro_valido and primeiro_canal return to 0 when alarme_memorizado returns to all-zero.
- ack with no alarms has no effect. Changing limiar mid-operation is undefined.

Decomposition:
- Package monitor_temp_pkg holds:
  - the state encoding (NORMAL, SUSPEITO, ALARME, RETORNO), 2 bits;
  - the counter width CNT_W=4;
  - the first-out index width 4.
- Sub-module canal_debounce_temp: one per channel via generate. It contains the FSM, counter and compare logic, and outputs the channel's alarm bit.
- Top level handles latching, ack, OR-reduction and first-out priority.

Test Plan:
- Core channel 0, limiar=40, DEB=3, samples 39,40,40 -> no alarm. Further sample 40 -> alarme_canal[0]=1 one clk after the 3rd consecutive 40; alarme_sonoro=1; primeiro_canal=0.
- Reactor channel 6, limiar=300, samples 300,300,299,300,300 -> no alarm (counter restarted). A 6th sample of 300 -> alarm.
- Hysteresis on channel 1, limiar=100, in alarm: samples 96 ×5 -> stays in alarm. Then 94,94,94 -> alarme_canal[1]=0 next clk, but alarme_memorizado[1] stays 1 until ack; after ack all bits 0.
- Channels 3 and 5 exceed on the same sample -> primeiro_canal=3. Channel 2 later -> primeiro_canal still 3. ack while all three are active -> nothing clears.
- amostra_valida=0 for 10 cycles between exceeding samples -> count is held, and the alarm asserts on the 3rd valid sample.
- Assert rst_n=0 mid-SUSPEITO and while alarms are latched -> all outputs 0 immediately. After release, 3 new samples are needed to alarm.
